cvs_logic_unit: RTL and testbench

// Parametrised successor to the fixed in0/AND/OR/NOT board-test logic. Conditions NUM_IN raw

---
 rtl/cvs_pkg.sv | 33 +++
 rtl/cvs_debounce.sv | 52 +++++
 rtl/cvs_logic_unit.sv | 85 ++++++++
 tb/tb_cvs_logic_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cvs_pkg.sv
// Shared types for the board-test logic unit: per-output function codes and their evaluation.
package cvs_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS,
        OP_AND,
        OP_OR,
        OP_NOT,
        OP_XOR,
        OP_NAND,
        OP_ZERO,
        OP_ONE
    } logic_op_e;

    function automatic logic apply_op(logic_op_e op, logic a, logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_PASS: r = a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = ~a;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_ZERO: r = 1'b0;
            OP_ONE:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cvs_debounce.sv
// One switch channel: two-flop synchroniser, stable-count debouncer and registered edge pulses.
module cvs_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 300_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          db_q;
    logic          db_dly_q;
    logic          rise_q;
    logic          fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            db_dly_q <= db_q;
            // Edges are taken from the committed level, so they trail in_db by one cycle.
            rise_q   <= db_q & ~db_dly_q;
            fall_q   <= ~db_q & db_dly_q;
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/cvs_logic_unit.sv
// Conditioned switch inputs feeding run-time selectable two-input logic outputs,
// plus the divided slow LED clock and its toggle tick.
module cvs_logic_unit
    import cvs_pkg::*;
#(
    parameter int unsigned NUM_IN          = 5,
    parameter int unsigned NUM_OUT         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 300_000,
    parameter int unsigned DIV_COUNT       = 100_000_000,
    localparam int unsigned SELW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk_300,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in,
    input  logic [NUM_OUT*OP_W-1:0] op,
    input  logic [NUM_OUT*SELW-1:0] a_sel,
    input  logic [NUM_OUT*SELW-1:0] b_sel,
    output logic [NUM_OUT-1:0]      out,
    output logic [NUM_IN-1:0]       in_db,
    output logic [NUM_IN-1:0]       rise,
    output logic [NUM_IN-1:0]       fall,
    output logic                    clk_slow,
    output logic                    slow_tick
);

    localparam int unsigned PADW = 1 << SELW;
    localparam int unsigned DIVW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV_COUNT - 1);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        cvs_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i (clk_300),
            .rst_i (rst),
            .raw_i (in[i]),
            .db_o  (in_db[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i])
        );
    end

    // Zero padding up to the full select range makes out-of-range indices read as 0.
    logic [PADW-1:0]    db_pad;
    logic [NUM_OUT-1:0] out_d;
    logic [NUM_OUT-1:0] out_q;

    assign db_pad = PADW'(in_db);

    always_comb begin
        out_d = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            out_d[k] = apply_op(logic_op_e'(op[OP_W*k +: OP_W]),
                                db_pad[a_sel[SELW*k +: SELW]],
                                db_pad[b_sel[SELW*k +: SELW]]);
        end
    end

    logic [DIVW-1:0] div_q;
    logic            clk_slow_q;
    logic            slow_tick_q;

    always_ff @(posedge clk_300) begin
        if (rst) begin
            out_q       <= '0;
            div_q       <= '0;
            clk_slow_q  <= 1'b0;
            slow_tick_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            slow_tick_q <= (div_q == DIV_LAST);
            if (div_q == DIV_LAST) begin
                div_q      <= '0;
                clk_slow_q <= ~clk_slow_q;
            end else begin
                div_q <= div_q + DIVW'(1);
            end
        end
    end

    assign out       = out_q;
    assign clk_slow  = clk_slow_q;
    assign slow_tick = slow_tick_q;

endmodule

// File: tb/tb_cvs_logic_unit.sv
// Directed and randomised bench for cvs_logic_unit against a window-based behavioural model.
module tb_cvs_logic_unit;

    localparam int unsigned NI = 5;
    localparam int unsigned NO = 4;
    localparam int unsigned SW = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned DV = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI-1:0]    in_r;
    logic [NO*3-1:0]  op_r;
    logic [NO*SW-1:0] asel_r;
    logic [NO*SW-1:0] bsel_r;
    logic [NO-1:0]    out_w;
    logic [NI-1:0]    in_db_w;
    logic [NI-1:0]    rise_w;
    logic [NI-1:0]    fall_w;
    logic             clk_slow_w;
    logic             slow_tick_w;

    int n_cmp = 0;
    int n_bad = 0;

    cvs_logic_unit #(
        .NUM_IN(NI),
        .NUM_OUT(NO),
        .DEBOUNCE_CYCLES(DB),
        .DIV_COUNT(DV)
    ) dut (
        .clk_300  (clk),
        .rst      (rst),
        .in       (in_r),
        .op       (op_r),
        .a_sel    (asel_r),
        .b_sel    (bsel_r),
        .out      (out_w),
        .in_db    (in_db_w),
        .rise     (rise_w),
        .fall     (fall_w),
        .clk_slow (clk_slow_w),
        .slow_tick(slow_tick_w)
    );

    always #5 clk = ~clk;

    // Model state: raw history (for the two-cycle sync delay), window of synced samples since reset.
    logic [NI-1:0] rawq[$];
    logic [NI-1:0] sq[$];
    logic [NI-1:0] m_db, m_db_prev, m_rise, m_fall;
    logic [NO-1:0] m_out;
    int unsigned   m_n;

    function automatic logic ref_fn(int unsigned code, logic a, logic b);
        case (code)
            0: return a;
            1: return a & b;
            2: return a | b;
            3: return ~a;
            4: return a ^ b;
            5: return ~(a & b);
            6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NI-1:0] s_pre, nd;
        logic [NO-1:0] no;
        logic          a, b, all_diff;
        int unsigned   ai, bi;
        if (rst) begin
            rawq.delete();
            sq.delete();
            m_db = '0; m_db_prev = '0; m_rise = '0; m_fall = '0; m_out = '0; m_n = 0;
        end else begin
            s_pre = (rawq.size() >= 2) ? rawq[1] : '0;
            rawq.push_front(in_r);
            if (rawq.size() > 2) void'(rawq.pop_back());
            sq.push_front(s_pre);
            if (sq.size() > DB) void'(sq.pop_back());
            for (int k = 0; k < NO; k++) begin
                ai = asel_r[SW*k +: SW];
                bi = bsel_r[SW*k +: SW];
                a = (ai < NI) ? m_db[ai] : 1'b0;
                b = (bi < NI) ? m_db[bi] : 1'b0;
                no[k] = ref_fn(op_r[3*k +: 3], a, b);
            end
            m_rise = m_db & ~m_db_prev;
            m_fall = ~m_db & m_db_prev;
            m_db_prev = m_db;
            // Level commits once the last DB synced samples all disagree with it.
            nd = m_db;
            for (int c = 0; c < NI; c++) begin
                all_diff = (sq.size() >= DB);
                for (int j = 0; j < sq.size(); j++)
                    if (sq[j][c] == m_db[c]) all_diff = 1'b0;
                if (all_diff) nd[c] = ~m_db[c];
            end
            m_db  = nd;
            m_out = no;
            m_n++;
        end
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("in_db", in_db_w, m_db);
            chk("rise", rise_w, m_rise);
            chk("fall", fall_w, m_fall);
            chk("out", out_w, m_out);
            chk("clk_slow", clk_slow_w, ((m_n / DV) % 2) == 1);
            chk("slow_tick", slow_tick_w, (m_n > 0) && (m_n % DV == 0));
        end
    endtask

    task automatic set_op(int k, int unsigned code, int unsigned a, int unsigned b);
        op_r[3*k +: 3]    = 3'(code);
        asel_r[SW*k +: SW] = SW'(a);
        bsel_r[SW*k +: SW] = SW'(b);
    endtask

    initial begin
        rst = 1'b1; in_r = '0; op_r = '0; asel_r = '0; bsel_r = '0;
        step(2);
        chk("reset_out", out_w, 0);
        rst = 1'b0;
        step(16);

        // Held rise on channel 0
        in_r[0] = 1'b1;
        step(5);
        chk("db0_at5", in_db_w[0], 0);
        step(1);
        chk("db0_at6", in_db_w[0], 1);
        chk("out0_at6", out_w[0], 0);
        step(1);
        chk("rise0_at7", rise_w[0], 1);
        chk("out0_at7", out_w[0], 1);
        step(1);
        chk("rise0_at8", rise_w[0], 0);

        // Three-cycle glitch on channel 1 must be swallowed
        in_r[1] = 1'b1;
        step(3);
        in_r[1] = 1'b0;
        step(8);
        chk("glitch_db1", in_db_w[1], 0);

        // Mixed functions
        in_r[1] = 1'b1;
        step(7);
        chk("db_00011", in_db_w, 5'b00011);
        set_op(0, 1, 0, 1);
        set_op(1, 2, 0, 2);
        set_op(2, 3, 2, 0);
        set_op(3, 4, 0, 1);
        step(1);
        chk("ops_0111", out_w, 4'b0111);
        set_op(3, 5, 0, 1);
        step(1);
        chk("nand_out3", out_w[3], 0);

        // Out-of-range select reads as 0
        set_op(0, 0, 7, 0);
        step(1);
        chk("sel7_a", out_w[0], 0);
        in_r = '1;
        step(8);
        chk("sel7_b", out_w[0], 0);

        // Reset mid-debounce (channel 4 falling, count 2) and mid-divide
        in_r[4] = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_db", in_db_w, 0);
        chk("rst_out", out_w, 0);
        chk("rst_slow", clk_slow_w, 0);
        step(4);
        chk("tick_at4", slow_tick_w, 0);
        step(1);
        chk("tick_at5", slow_tick_w, 1);
        chk("db0_rst5", in_db_w[0], 0);
        step(1);
        chk("db0_rst6", in_db_w[0], 1);

        // Randomised traffic
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < NI; c++)
                if ($urandom_range(7) == 0) in_r[c] = ~in_r[c];
            if ($urandom_range(9) == 0)
                set_op($urandom_range(NO - 1), $urandom_range(7), $urandom_range(7), $urandom_range(7));
            rst = ($urandom_range(99) == 0);
            step(1);
        end
        rst = 1'b0;
        step(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
